// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC pipeline flag/branch logic.
//  - opcode encodings (OP_ADD .. OP_HLT)
//  - branch condition codes (CC_NE .. CC_UNC)
//  - bit positions of Z/V/N inside the 3-bit flag vector {Z,V,N}
//  - branch sequencing FSM state type
//  - helpers that decide which flags an EX opcode writes
package wisc_pkg;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;
    localparam logic [3:0] OP_LW     = 4'b1000;
    localparam logic [3:0] OP_SW     = 4'b1001;
    localparam logic [3:0] OP_LLB    = 4'b1010;
    localparam logic [3:0] OP_LHB    = 4'b1011;
    localparam logic [3:0] OP_B      = 4'b1100;
    localparam logic [3:0] OP_BR     = 4'b1101;
    localparam logic [3:0] OP_PCS    = 4'b1110;
    localparam logic [3:0] OP_HLT    = 4'b1111;

    localparam logic [2:0] CC_NE   = 3'b000;
    localparam logic [2:0] CC_EQ   = 3'b001;
    localparam logic [2:0] CC_GT   = 3'b010;
    localparam logic [2:0] CC_LT   = 3'b011;
    localparam logic [2:0] CC_GE   = 3'b100;
    localparam logic [2:0] CC_LE   = 3'b101;
    localparam logic [2:0] CC_OVFL = 3'b110;
    localparam logic [2:0] CC_UNC  = 3'b111;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } br_state_e;

    // Z is produced by every ALU op that has a meaningful zero result.
    function automatic logic writes_z(input logic [3:0] op);
        logic w;
        w = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_XOR, OP_SLL, OP_SRA, OP_ROR: w = 1'b1;
            default: w = 1'b0;
        endcase
        return w;
    endfunction

    // Overflow and sign are only defined for the arithmetic ops.
    function automatic logic writes_vn(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator (purely combinational).
// Ports:
//  ccc   in  3  branch condition code
//  flag  in  3  flags {Z,V,N} to test
//  taken out 1  condition is true
module cond_eval
    import wisc_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] flag,
    output logic       taken
);

    logic z;
    logic v;
    logic n;

    assign z = flag[FLAG_Z];
    assign v = flag[FLAG_V];
    assign n = flag[FLAG_N];

    always_comb begin
        taken = 1'b0;
        case (ccc)
            CC_NE:   taken = !z;
            CC_EQ:   taken = z;
            CC_GT:   taken = !z && !n;
            CC_LT:   taken = n;
            CC_GE:   taken = z || !n;
            CC_LE:   taken = n || z;
            CC_OVFL: taken = v;
            CC_UNC:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_ctrl.sv
// Z/V/N flag register and conditional-branch sequencing for the 5-stage
// WISC pipeline. Flags are written at the EX->MEM edge; branches resolve in
// ID. A branch in ID that depends on flags an EX instruction is about to
// write either stalls one cycle (BYPASS=0) or resolves against the
// forwarded next-flag value (BYPASS=1).
//
// Handshake: there is no valid/ready pairing here. br_resolved qualifies
// br_taken in the same cycle; br_stall asks IF/ID to hold this cycle. All
// three are combinational from the current state and inputs.
//
// Ports:
//  clk          in   1      clock, state on posedge
//  rst          in   1      asynchronous reset, active low
//  hold         in   1      global pipeline stall, freezes all state
//  flush        in   1      squash the instruction in ID
//  id_valid     in   1      ID holds a valid instruction
//  id_opcode    in   4      ID opcode
//  id_ccc       in   3      ID branch condition code
//  ex_valid     in   1      EX holds a valid instruction
//  ex_opcode    in   4      EX opcode
//  ex_Z/V/N     in   1      ALU result flags from EX
//  flag         out  3      architectural flags {Z,V,N}
//  br_stall     out  1      flag-hazard stall of IF/ID
//  br_resolved  out  1      branch in ID resolved this cycle
//  br_taken     out  1      branch condition true (with br_resolved)
//  stall_cnt    out  CNT_W  saturating count of stall cycles
//  dbg_state    out  1      current FSM state (IDLE=0, WAIT=1)
module flag_branch_ctrl
    import wisc_pkg::*;
#(
    parameter int BYPASS = 0,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [3:0]       id_opcode,
    input  logic [2:0]       id_ccc,
    input  logic             ex_valid,
    input  logic [3:0]       ex_opcode,
    input  logic             ex_Z,
    input  logic             ex_V,
    input  logic             ex_N,
    output logic [2:0]       flag,
    output logic             br_stall,
    output logic             br_resolved,
    output logic             br_taken,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             dbg_state
);

    br_state_e        state_q, state_d;
    logic [2:0]       flag_q, flag_d;
    logic [2:0]       next_flag;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic is_br;
    logic ex_wr_z;
    logic ex_wr_vn;
    logic hazard;
    logic taken_cur;
    logic taken_next;

    assign is_br    = id_valid && ((id_opcode == OP_B) || (id_opcode == OP_BR));
    assign ex_wr_z  = ex_valid && writes_z(ex_opcode);
    assign ex_wr_vn = ex_valid && writes_vn(ex_opcode);
    // An unconditional branch never looks at the flags, so it cannot hazard.
    assign hazard   = is_br && (ex_wr_z || ex_wr_vn) && (id_ccc != CC_UNC);

    // Flags as they will be after this edge if EX writes them; doubles as the
    // bypass value for a dependent branch in ID.
    always_comb begin
        next_flag = flag_q;
        if (ex_wr_z) begin
            next_flag[FLAG_Z] = ex_Z;
        end
        if (ex_wr_vn) begin
            next_flag[FLAG_V] = ex_V;
            next_flag[FLAG_N] = ex_N;
        end
    end

    // Flush does not block the write: the EX instruction is older than the
    // one being squashed in ID.
    assign flag_d = hold ? flag_q : next_flag;

    cond_eval u_cond_cur (
        .ccc   (id_ccc),
        .flag  (flag_q),
        .taken (taken_cur)
    );

    cond_eval u_cond_next (
        .ccc   (id_ccc),
        .flag  (next_flag),
        .taken (taken_next)
    );

    always_comb begin
        state_d     = state_q;
        br_stall    = 1'b0;
        br_resolved = 1'b0;
        br_taken    = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_br) begin
                    if (!hazard) begin
                        br_resolved = 1'b1;
                        br_taken    = taken_cur;
                    end else if (BYPASS != 0) begin
                        br_resolved = 1'b1;
                        br_taken    = taken_next;
                    end else begin
                        br_stall = 1'b1;
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                // Producer has retired into flag_q; any new EX producer is
                // re-checked once back in IDLE.
                if (is_br) begin
                    br_resolved = 1'b1;
                    br_taken    = taken_cur;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            br_stall    = 1'b0;
            br_resolved = 1'b0;
            br_taken    = 1'b0;
            state_d     = IDLE;
        end
        // Keep branch outputs at their reset values while reset is held.
        if (!rst) begin
            br_stall    = 1'b0;
            br_resolved = 1'b0;
            br_taken    = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (br_stall && !hold && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            flag_q      <= 3'b000;
            stall_cnt_q <= '0;
        end else begin
            flag_q      <= flag_d;
            stall_cnt_q <= stall_cnt_d;
            // Flush wins over hold so a squashed WAIT cannot linger.
            if (flush || !hold) begin
                state_q <= state_d;
            end
        end
    end

    assign flag      = flag_q;
    assign stall_cnt = stall_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_flag_branch_ctrl.sv
module tb_flag_branch_ctrl;

    localparam int VW = 52;

    logic clk = 1'b0;
    logic rst;
    logic hold, flush, id_valid, ex_valid, ex_Z, ex_V, ex_N;
    logic [3:0] id_opcode, ex_opcode;
    logic [2:0] id_ccc;

    // stall instance (m), bypass instance (b), 2-bit counter instance (s)
    logic [2:0]  flag_m, flag_b, flag_s;
    logic        stall_m, res_m, tk_m, st_m;
    logic        stall_b, res_b, tk_b, st_b;
    logic        stall_s, res_s, tk_s, st_s;
    logic [15:0] cnt_m, cnt_b;
    logic [1:0]  cnt_s;

    logic [VW-1:0] exp_q[$];
    string         tag_q[$];
    logic [VW-1:0] obs_vec;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    flag_branch_ctrl #(.BYPASS(0), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_opcode(id_opcode), .id_ccc(id_ccc), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_Z(ex_Z), .ex_V(ex_V), .ex_N(ex_N), .flag(flag_m), .br_stall(stall_m),
        .br_resolved(res_m), .br_taken(tk_m), .stall_cnt(cnt_m), .dbg_state(st_m)
    );

    flag_branch_ctrl #(.BYPASS(1), .CNT_W(16)) u_byp (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_opcode(id_opcode), .id_ccc(id_ccc), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_Z(ex_Z), .ex_V(ex_V), .ex_N(ex_N), .flag(flag_b), .br_stall(stall_b),
        .br_resolved(res_b), .br_taken(tk_b), .stall_cnt(cnt_b), .dbg_state(st_b)
    );

    flag_branch_ctrl #(.BYPASS(0), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_opcode(id_opcode), .id_ccc(id_ccc), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_Z(ex_Z), .ex_V(ex_V), .ex_N(ex_N), .flag(flag_s), .br_stall(stall_s),
        .br_resolved(res_s), .br_taken(tk_s), .stall_cnt(cnt_s), .dbg_state(st_s)
    );

    // The 2-bit instance shares stimulus with u_dut, so only its counter
    // differs; its branch outputs are expected equal to u_dut's expected.
    assign obs_vec = {flag_m, flag_b, flag_s,
                      stall_m, res_m, tk_m,
                      st_m, st_b, st_s,
                      cnt_m, cnt_b,
                      stall_b, res_b, tk_b,
                      cnt_s};

    logic [2:0] br_s_chk;
    always_comb br_s_chk = {stall_s, res_s, tk_s};

    task automatic drv(input logic h, input logic f, input logic idv, input logic [3:0] idop,
                       input logic [2:0] ccc, input logic exv, input logic [3:0] exop,
                       input logic [2:0] zvn);
        hold = h; flush = f; id_valid = idv; id_opcode = idop; id_ccc = ccc;
        ex_valid = exv; ex_opcode = exop; {ex_Z, ex_V, ex_N} = zvn;
    endtask

    // e_br = {br_stall, br_resolved, br_taken} of the stall instance,
    // e_b the same for the bypass instance.
    task automatic push(input string tag, input logic [2:0] e_flag, input logic [2:0] e_br,
                        input logic e_st, input logic [15:0] e_cnt, input logic [2:0] e_b,
                        input logic [1:0] e_s);
        exp_q.push_back({e_flag, e_flag, e_flag, e_br, e_st, 1'b0, e_st,
                         e_cnt, 16'h0000, e_b, e_s});
        tag_q.push_back(tag);
    endtask

    task automatic compare_pop(input logic [2:0] e_br);
        logic [VW-1:0] exp;
        string t;
        exp = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs_vec === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", t, obs_vec, exp);
        end
        checks++;
        assert (br_s_chk === e_br) else begin
            errors++;
            $error("FAIL %s_sat_br observed=%b expected=%b", t, br_s_chk, e_br);
        end
    endtask

    task automatic step(input string tag, input logic [2:0] e_flag, input logic [2:0] e_br,
                        input logic e_st, input logic [15:0] e_cnt, input logic [2:0] e_b,
                        input logic [1:0] e_s);
        push(tag, e_flag, e_br, e_st, e_cnt, e_b, e_s);
        @(negedge clk);
        compare_pop(e_br);
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string tag, input logic [2:0] e_flag, input logic [2:0] e_br,
                             input logic e_st, input logic [15:0] e_cnt, input logic [2:0] e_b,
                             input logic [1:0] e_s);
        push(tag, e_flag, e_br, e_st, e_cnt, e_b, e_s);
        compare_pop(e_br);
    endtask

    initial begin
        rst = 1'b0;
        drv(0, 0, 0, 4'h0, 3'b000, 0, 4'h0, 3'b000);
        @(posedge clk);
        #1;
        step("reset",       3'b000, 3'b000, 0, 16'd0, 3'b000, 2'd0);
        rst = 1'b1;

        // ADD 0x7FFF+1 -> Z=0 V=1 N=1
        drv(0, 0, 0, 4'h0, 3'b000, 1, 4'b0000, 3'b011);
        step("t1_add",      3'b000, 3'b000, 0, 16'd0, 3'b000, 2'd0);
        drv(0, 0, 0, 4'h0, 3'b000, 0, 4'h0, 3'b000);
        step("t1_flag",     3'b011, 3'b000, 0, 16'd0, 3'b000, 2'd0);

        // EQ branch vs XOR producing zero
        drv(0, 0, 1, 4'b1100, 3'b001, 1, 4'b0010, 3'b100);
        step("t2_haz",      3'b011, 3'b100, 0, 16'd0, 3'b011, 2'd0);
        drv(0, 0, 1, 4'b1100, 3'b001, 0, 4'h0, 3'b000);
        step("t2_res",      3'b111, 3'b011, 1, 16'd1, 3'b011, 2'd1);
        drv(0, 0, 0, 4'h0, 3'b000, 0, 4'h0, 3'b000);
        step("t2_idle",     3'b111, 3'b000, 0, 16'd1, 3'b000, 2'd1);

        // LW writes no flags; OVFL with V=1; unconditional vs ADD
        drv(0, 0, 1, 4'b1100, 3'b110, 1, 4'b1000, 3'b000);
        step("t4_lw_ovfl",  3'b111, 3'b011, 0, 16'd1, 3'b011, 2'd1);
        drv(0, 0, 1, 4'b1100, 3'b111, 1, 4'b0000, 3'b000);
        step("t4_unc",      3'b111, 3'b011, 0, 16'd1, 3'b011, 2'd1);
        drv(0, 0, 1, 4'b1101, 3'b001, 0, 4'h0, 3'b000);
        step("t4_br_eq_nt", 3'b000, 3'b010, 0, 16'd1, 3'b010, 2'd1);
        drv(0, 0, 1, 4'b1100, 3'b010, 0, 4'h0, 3'b000);
        step("t4_gt",       3'b000, 3'b011, 0, 16'd1, 3'b011, 2'd1);

        // LT vs SUB producing N=1, then hold in WAIT with a blocked ADD in EX
        drv(0, 0, 1, 4'b1100, 3'b011, 1, 4'b0001, 3'b001);
        step("t5_haz",      3'b000, 3'b100, 0, 16'd1, 3'b011, 2'd1);
        drv(1, 0, 1, 4'b1100, 3'b011, 1, 4'b0000, 3'b100);
        step("t5_hold1",    3'b001, 3'b011, 1, 16'd2, 3'b010, 2'd2);
        step("t5_hold2",    3'b001, 3'b011, 1, 16'd2, 3'b010, 2'd2);
        step("t5_hold3",    3'b001, 3'b011, 1, 16'd2, 3'b010, 2'd2);
        drv(0, 0, 1, 4'b1100, 3'b011, 0, 4'h0, 3'b000);
        step("t5_release",  3'b001, 3'b011, 1, 16'd2, 3'b011, 2'd2);

        // hold while a hazard is pending in IDLE: stall stays up, count frozen
        drv(1, 0, 1, 4'b1100, 3'b001, 1, 4'b0000, 3'b100);
        step("t5_hstall1",  3'b001, 3'b100, 0, 16'd2, 3'b011, 2'd2);
        step("t5_hstall2",  3'b001, 3'b100, 0, 16'd2, 3'b011, 2'd2);
        drv(0, 0, 1, 4'b1100, 3'b001, 1, 4'b0000, 3'b100);
        step("t5_hstall3",  3'b001, 3'b100, 0, 16'd2, 3'b011, 2'd2);
        drv(0, 0, 1, 4'b1100, 3'b001, 0, 4'h0, 3'b000);
        step("t5_hres",     3'b100, 3'b011, 1, 16'd3, 3'b011, 2'd3);

        // one more stall: 2-bit counter stays at all-ones
        drv(0, 0, 1, 4'b1100, 3'b001, 1, 4'b0010, 3'b000);
        step("t6_sat",      3'b100, 3'b100, 0, 16'd3, 3'b010, 2'd3);

        // flush in WAIT; flag write still lands
        drv(0, 1, 1, 4'b1100, 3'b001, 1, 4'b0000, 3'b010);
        step("t6_flush",    3'b000, 3'b000, 1, 16'd4, 3'b000, 2'd3);
        drv(0, 0, 0, 4'h0, 3'b000, 0, 4'h0, 3'b000);
        step("t6_postfl",   3'b010, 3'b000, 0, 16'd4, 3'b000, 2'd3);

        // flush beats hold for the state update
        drv(0, 0, 1, 4'b1100, 3'b110, 1, 4'b0001, 3'b000);
        step("t6_haz2",     3'b010, 3'b100, 0, 16'd4, 3'b010, 2'd3);
        drv(1, 1, 1, 4'b1100, 3'b110, 0, 4'h0, 3'b000);
        step("t6_flhold",   3'b000, 3'b000, 1, 16'd5, 3'b000, 2'd3);
        drv(0, 0, 0, 4'h0, 3'b000, 0, 4'h0, 3'b000);
        step("t6_postflh",  3'b000, 3'b000, 0, 16'd5, 3'b000, 2'd3);

        // reset asserted mid-WAIT with the branch still presented
        drv(0, 0, 1, 4'b1100, 3'b001, 1, 4'b0010, 3'b100);
        step("t6_haz3",     3'b000, 3'b100, 0, 16'd5, 3'b011, 2'd3);
        drv(0, 0, 1, 4'b1100, 3'b001, 0, 4'h0, 3'b000);
        rst = 1'b0;
        #1;
        check_now("t6_rst_wait", 3'b000, 3'b000, 0, 16'd0, 3'b000, 2'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_now("t6_represent", 3'b000, 3'b010, 0, 16'd0, 3'b010, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
